// File: rtl/axi_w_pkg.sv
// Shared types for the AXI W-channel burst packer.
// Beat type defaults to a 32-bit payload; the top rebuilds it for its own width.
package axi_w_pkg;

   localparam int unsigned DefDataWidth = 32;

   typedef enum logic {
      IDLE,
      BURST
   } w_pack_state_e;

   typedef struct packed {
      logic [DefDataWidth-1:0] data;
      logic                    last;
   } w_beat_t;

endpackage

// File: rtl/w_beat_reg.sv
// Single-entry valid/ready register slice for one W beat.
// Flush drops the held beat and clears its last flag.
module w_beat_reg
   import axi_w_pkg::*;
#(
   parameter type beat_t = w_beat_t
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  flush_i,
   input  logic  in_valid_i,
   output logic  in_ready_o,
   input  beat_t in_beat_i,
   output logic  out_valid_o,
   input  logic  out_ready_i,
   output beat_t out_beat_o
);

   logic  valid_q, valid_d;
   beat_t beat_q, beat_d;

   assign in_ready_o  = ~valid_q | out_ready_i;
   assign out_valid_o = valid_q;
   assign out_beat_o  = beat_q;

   always_comb begin
      valid_d = valid_q;
      beat_d  = beat_q;
      if (flush_i) begin
         valid_d     = 1'b0;
         beat_d.last = 1'b0;
      end else if (in_valid_i) begin
         valid_d = 1'b1;
         beat_d  = in_beat_i;
      end else if (valid_q & out_ready_i) begin
         valid_d     = 1'b0;
         beat_d.last = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: rtl/axi_w_burst_packer.sv
// Drains the W-data FIFO into AXI4 W beats, framing bursts by AWLEN.
// Output goes through a register slice so w_* never see the FIFO combinationally.
module axi_w_burst_packer
   import axi_w_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [LEN_WIDTH-1:0]  cmd_len_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_pop_o,
   output logic                  w_valid_o,
   input  logic                  w_ready_i,
   output logic [DATA_WIDTH-1:0] w_data_o,
   output logic                  w_last_o,
   output logic                  busy_o
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } beat_t;

   w_pack_state_e        state_q, state_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 slot_free;
   logic                 load;
   beat_t                beat_in;
   beat_t                beat_out;

   assign load       = (state_q == BURST) & ~fifo_empty_i
                     & slot_free & ~flush_i;
   assign fifo_pop_o = load;
   assign beat_in    = '{data: fifo_data_i, last: (cnt_q == '0)};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_ready_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            // a flushing cycle must not swallow a command
            cmd_ready_o = ~flush_i;
            if (cmd_valid_i & ~flush_i) begin
               cnt_d   = cmd_len_i;
               state_d = BURST;
            end
         end
         BURST: begin
            if (load) begin
               if (cnt_q == '0) state_d = IDLE;
               else cnt_d = cnt_q - LEN_WIDTH'(1);
            end
         end
         default: ;
      endcase
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   w_beat_reg #(
      .beat_t (beat_t)
   ) u_beat_reg (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_valid_i  (load),
      .in_ready_o  (slot_free),
      .in_beat_i   (beat_in),
      .out_valid_o (w_valid_o),
      .out_ready_i (w_ready_i),
      .out_beat_o  (beat_out)
   );

   assign w_data_o = beat_out.data;
   assign w_last_o = beat_out.last;
   assign busy_o   = (state_q == BURST) | w_valid_o;

`ifndef SYNTHESIS
   a_no_pop_empty: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      fifo_empty_i |-> !fifo_pop_o);

   a_hold_stable: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (w_valid_o && !w_ready_i && !flush_i)
      |=> ($stable(w_data_o) && $stable(w_last_o)));

   a_no_cmd_in_burst: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (state_q == BURST) |-> !cmd_ready_o);
`endif

endmodule

// File: tb/tb_axi_w_burst_packer.sv
// Randomized bench for axi_w_burst_packer against a queue-based burst model.
// Expected beats come from splitting the pushed FIFO words by command length.
module tb_axi_w_burst_packer;

   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          flush_i = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic [LW-1:0] cmd_len_i = '0;
   logic          fifo_empty_i = 1'b1;
   logic [DW-1:0] fifo_data_i = '0;
   logic          fifo_pop_o;
   logic          w_valid_o;
   logic          w_ready_i = 1'b0;
   logic [DW-1:0] w_data_o;
   logic          w_last_o;
   logic          busy_o;

   always #5 clk_i = ~clk_i;

   axi_w_burst_packer #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_len_i    (cmd_len_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_pop_o   (fifo_pop_o),
      .w_valid_o    (w_valid_o),
      .w_ready_i    (w_ready_i),
      .w_data_o     (w_data_o),
      .w_last_o     (w_last_o),
      .busy_o       (busy_o)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_s;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] src_q[$];
   int            cmd_q[$];
   beat_s         exp_q[$];
   int            cmd_cyc[$];
   int            beat_cyc[$];
   bit            rdy_hist[$];
   bit            pop_hist[$];
   bit            val_hist[$];

   int            cyc;
   int            pops;
   int            ready_mode;
   int            gap_at;
   int            gap_len;
   int            empty_hold;
   int            flush_at;
   bit            rand_gaps;
   bit            prev_hold;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   task automatic clear_model();
      fifo_q.delete();
      src_q.delete();
      cmd_q.delete();
      exp_q.delete();
      cmd_cyc.delete();
      beat_cyc.delete();
      rdy_hist.delete();
      pop_hist.delete();
      val_hist.delete();
      cyc        = 0;
      pops       = 0;
      ready_mode = 0;
      gap_at     = -1;
      gap_len    = 0;
      empty_hold = 0;
      flush_at   = -1;
      rand_gaps  = 1'b0;
      prev_hold  = 1'b0;
   endtask

   task automatic push_data(input int n);
      logic [DW-1:0] d;
      for (int i = 0; i < n; i++) begin
         d = $urandom;
         fifo_q.push_back(d);
         src_q.push_back(d);
      end
   endtask

   // one clock: drive at negedge, observe the upcoming edge's handshakes
   task automatic step();
      int    len;
      beat_s b;
      @(negedge clk_i);
      if (prev_hold) begin
         checks++;
         if (w_data_o !== prev_data || w_last_o !== prev_last) begin
            errors++;
            $display("FAIL hold_stable cyc=%0d: got data=%h last=%b want data=%h last=%b",
                     cyc, w_data_o, w_last_o, prev_data, prev_last);
         end
      end
      flush_i     = (cyc == flush_at);
      cmd_valid_i = (cmd_q.size() > 0);
      cmd_len_i   = (cmd_q.size() > 0) ? LW'(cmd_q[0]) : '0;
      case (ready_mode)
         0:       w_ready_i = 1'b1;
         1:       w_ready_i = ($urandom_range(0, 3) != 0);
         default: w_ready_i = !(cyc >= 3 && cyc <= 6);
      endcase
      if (gap_at >= 0 && pops == gap_at) begin
         empty_hold = gap_len;
         gap_at     = -1;
      end
      if (rand_gaps && empty_hold == 0 && $urandom_range(0, 7) == 0)
         empty_hold = $urandom_range(1, 3);
      fifo_empty_i = (fifo_q.size() == 0) || (empty_hold > 0);
      fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : DW'($urandom);
      if (empty_hold > 0) empty_hold--;
      #1;
      rdy_hist.push_back(cmd_ready_o);
      pop_hist.push_back(fifo_pop_o);
      val_hist.push_back(w_valid_o);
      checks++;
      if (fifo_pop_o && fifo_empty_i) begin
         errors++;
         $display("FAIL pop_while_empty cyc=%0d: got pop=1 want pop=0", cyc);
      end
      if (flush_i) begin
         checks++;
         if (fifo_pop_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_pop cyc=%0d: got pop=%b want 0", cyc, fifo_pop_o);
         end
      end
      if (cmd_valid_i && cmd_ready_o && !flush_i) begin
         len = cmd_q.pop_front();
         cmd_cyc.push_back(cyc);
         for (int k = 0; k <= len; k++) begin
            b.data = (src_q.size() > 0) ? src_q.pop_front() : '0;
            b.last = (k == len);
            exp_q.push_back(b);
         end
      end
      if (fifo_pop_o && !fifo_empty_i) begin
         void'(fifo_q.pop_front());
         pops++;
      end
      if (w_valid_o && w_ready_i && !flush_i) begin
         beat_cyc.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat cyc=%0d: got data=%h want no beat", cyc, w_data_o);
         end else begin
            b = exp_q.pop_front();
            if (w_data_o !== b.data || w_last_o !== b.last) begin
               errors++;
               $display("FAIL beat cyc=%0d: got data=%h last=%b want data=%h last=%b",
                        cyc, w_data_o, w_last_o, b.data, b.last);
            end
         end
      end
      prev_hold = w_valid_o && !w_ready_i && !flush_i;
      prev_data = w_data_o;
      prev_last = w_last_o;
      cyc++;
   endtask

   task automatic run_to_done(input int budget);
      int start;
      start = cyc;
      do step();
      while ((cmd_q.size() > 0 || exp_q.size() > 0) && (cyc - start) < budget);
      step();
      checks++;
      if (cmd_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL completion: got cmds_left=%0d beats_left=%0d want 0/0",
                  cmd_q.size(), exp_q.size());
      end
      checks++;
      if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL idle_after: got busy=%b cmd_ready=%b want 0/1", busy_o, cmd_ready_o);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (w_valid_o !== 1'b0 || w_last_o !== 1'b0 || w_data_o !== '0 ||
          fifo_pop_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s: got v=%b l=%b d=%h pop=%b rdy=%b busy=%b want 0 0 0 0 1 0",
                  tag, w_valid_o, w_last_o, w_data_o, fifo_pop_o, cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_reset();
      clear_model();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      check_reset_values("reset_state");
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_single_burst();
      clear_model();
      push_data(4);
      cmd_q.push_back(3);
      run_to_done(50);
      checks++;
      if (cmd_cyc.size() != 1 || beat_cyc.size() != 4) begin
         errors++;
         $display("FAIL s1_counts: got cmds=%0d beats=%0d want 1/4",
                  cmd_cyc.size(), beat_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (beat_cyc[i] != cmd_cyc[0] + 2 + i) begin
               errors++;
               $display("FAIL s1_latency beat%0d: got cyc=%0d want %0d",
                        i, beat_cyc[i], cmd_cyc[0] + 2 + i);
            end
         end
      end
      checks++;
      if (pops != 4) begin
         errors++;
         $display("FAIL s1_pops: got %0d want 4", pops);
      end
   endtask

   task automatic test_len0();
      clear_model();
      push_data(1);
      cmd_q.push_back(0);
      run_to_done(20);
      checks++;
      if (cmd_cyc.size() != 1 || rdy_hist.size() < 3) begin
         errors++;
         $display("FAIL s2_counts: got cmds=%0d want 1", cmd_cyc.size());
      end else if (rdy_hist[cmd_cyc[0] + 1] !== 1'b0 ||
                   rdy_hist[cmd_cyc[0] + 2] !== 1'b1) begin
         errors++;
         $display("FAIL s2_cmd_ready: got c1=%b c2=%b want 0/1",
                  rdy_hist[cmd_cyc[0] + 1], rdy_hist[cmd_cyc[0] + 2]);
      end
   endtask

   task automatic test_backpressure();
      clear_model();
      ready_mode = 2;
      push_data(4);
      cmd_q.push_back(3);
      run_to_done(50);
      checks++;
      if (beat_cyc.size() != 4) begin
         errors++;
         $display("FAIL s3_beats: got %0d want 4", beat_cyc.size());
      end
      for (int c = 3; c <= 6; c++) begin
         checks++;
         if (pop_hist[c] !== 1'b0) begin
            errors++;
            $display("FAIL s3_no_pop cyc=%0d: got pop=%b want 0", c, pop_hist[c]);
         end
      end
   endtask

   task automatic test_fifo_gap();
      clear_model();
      gap_at  = 2;
      gap_len = 3;
      push_data(4);
      cmd_q.push_back(3);
      run_to_done(50);
      for (int c = 3; c <= 5; c++) begin
         checks++;
         if (pop_hist[c] !== 1'b0) begin
            errors++;
            $display("FAIL s4_no_pop cyc=%0d: got pop=%b want 0", c, pop_hist[c]);
         end
      end
      checks++;
      if (val_hist[4] !== 1'b0) begin
         errors++;
         $display("FAIL s4_bubble: got w_valid=%b want 0", val_hist[4]);
      end
   endtask

   task automatic test_back_to_back();
      clear_model();
      push_data(5);
      cmd_q.push_back(1);
      cmd_q.push_back(2);
      run_to_done(50);
      checks++;
      if (cmd_cyc.size() != 2 || beat_cyc.size() != 5) begin
         errors++;
         $display("FAIL s5_counts: got cmds=%0d beats=%0d want 2/5",
                  cmd_cyc.size(), beat_cyc.size());
      end else if (cmd_cyc[1] != cmd_cyc[0] + 3) begin
         errors++;
         $display("FAIL s5_second_cmd: got cyc=%0d want %0d", cmd_cyc[1], cmd_cyc[0] + 3);
      end
   endtask

   task automatic test_flush();
      clear_model();
      push_data(8);
      cmd_q.push_back(7);
      flush_at = 3;
      repeat (5) step();
      checks++;
      if (w_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL s6_flush: got v=%b busy=%b rdy=%b want 0/0/1",
                  w_valid_o, busy_o, cmd_ready_o);
      end
      clear_model();
      push_data(1);
      cmd_q.push_back(0);
      run_to_done(20);
   endtask

   task automatic test_reset_mid_burst();
      clear_model();
      push_data(8);
      cmd_q.push_back(7);
      repeat (4) step();
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check_reset_values("s6_reset_mid");
      clear_model();
      cmd_valid_i  = 1'b0;
      fifo_empty_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      push_data(2);
      cmd_q.push_back(1);
      run_to_done(20);
   endtask

   task automatic test_random();
      int len;
      for (int it = 0; it < 6; it++) begin
         clear_model();
         ready_mode = 1;
         rand_gaps  = 1'b1;
         for (int j = 0; j < 6; j++) begin
            len = $urandom_range(0, 6);
            cmd_q.push_back(len);
            push_data(len + 1);
         end
         run_to_done(1000);
      end
   endtask

   task automatic test_max_len();
      clear_model();
      ready_mode = 1;
      push_data(256);
      cmd_q.push_back(255);
      run_to_done(3000);
      checks++;
      if (beat_cyc.size() != 256 || pops != 256) begin
         errors++;
         $display("FAIL max_len: got beats=%0d pops=%0d want 256/256",
                  beat_cyc.size(), pops);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_len0();
      test_backpressure();
      test_fifo_gap();
      test_back_to_back();
      test_flush();
      test_reset_mid_burst();
      test_random();
      test_max_len();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
